mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer_pkg.sv | 22 ++
 rtl/mac_skew_feeder.sv | 51 +++++
 rtl/mac_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_mac_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC tile sequencer.
// FSM state encodings, flush length and operand lane indices.
// Pure definitions; no logic, no latency, no backpressure.
package mac_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        FEED     = 3'd2,
        FLUSH    = 3'd3,
        WAIT_ACC = 3'd4,
        OUTPUT   = 3'd5
    } state_t;

    // Buffer read latency (1) plus the extra lane1 skew stage (2) after the last read
    localparam int FLUSH_CYCLES = 3;

    // Lane positions inside a 2*WIDTH operand buffer word
    localparam int LANE0 = 0;
    localparam int LANE1 = 1;

endpackage

// File: rtl/mac_skew_feeder.sv
// Operand skew registers: lane0 delayed 1 stage, lane1 delayed 2 stages.
// Latency: lane0 1 cycle, lane1 2 cycles from valid read data.
// No backpressure; data without a valid read behind it becomes zero.
module mac_skew_feeder
    import mac_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_vld,
    input  logic [2*WIDTH-1:0] i_a_dat,
    input  logic [2*WIDTH-1:0] i_b_dat,
    output logic [WIDTH-1:0]   o_west0,
    output logic [WIDTH-1:0]   o_west2,
    output logic [WIDTH-1:0]   o_north0,
    output logic [WIDTH-1:0]   o_north1
);

    logic [WIDTH-1:0] r_west0;
    logic [WIDTH-1:0] r_north0;
    logic [WIDTH-1:0] r_a1_s1;
    logic [WIDTH-1:0] r_b1_s1;
    logic [WIDTH-1:0] r_west2;
    logic [WIDTH-1:0] r_north1;

    // Register lane0 once and lane1 twice so the second MAC row/column lags by a cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_west0  <= '0;
            r_north0 <= '0;
            r_a1_s1  <= '0;
            r_b1_s1  <= '0;
            r_west2  <= '0;
            r_north1 <= '0;
        end else begin
            r_west0  <= i_vld ? i_a_dat[LANE0*WIDTH +: WIDTH] : '0;
            r_north0 <= i_vld ? i_b_dat[LANE0*WIDTH +: WIDTH] : '0;
            r_a1_s1  <= i_vld ? i_a_dat[LANE1*WIDTH +: WIDTH] : '0;
            r_b1_s1  <= i_vld ? i_b_dat[LANE1*WIDTH +: WIDTH] : '0;
            r_west2  <= r_a1_s1;
            r_north1 <= r_b1_s1;
        end
    end

    assign o_west0  = r_west0;
    assign o_north0 = r_north0;
    assign o_west2  = r_west2;
    assign o_north1 = r_north1;

endmodule

// File: rtl/mac_sequencer.sv
// Sequences tiled 2x2 MAC jobs: clear, stream K operands, flush, capture result.
// Latency per tile: 1 clear + INNER_DIMENSION feed + 3 flush + acc wait + output.
// Result register holds until res_ready; next tile's reads wait for that handshake.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int CHUNK_SIZE      = 4,
    parameter int INNER_DIMENSION = 64,
    parameter int AW              = 12,
    parameter int TW              = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [TW-1:0]               num_tiles,
    output logic                        busy,
    output logic                        done,
    output logic                        a_rd_en,
    output logic                        b_rd_en,
    output logic [AW-1:0]               a_rd_addr,
    output logic [AW-1:0]               b_rd_addr,
    input  logic [2*WIDTH-1:0]          a_rd_data,
    input  logic [2*WIDTH-1:0]          b_rd_data,
    output logic                        mac_rst_n,
    output logic                        mac_reset_acc,
    output logic [WIDTH-1:0]            mac_west0,
    output logic [WIDTH-1:0]            mac_west2,
    output logic [WIDTH-1:0]            mac_north0,
    output logic [WIDTH-1:0]            mac_north1,
    input  logic                        mac_acc_done,
    input  logic [WIDTH*CHUNK_SIZE-1:0] mac_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [WIDTH*CHUNK_SIZE-1:0] res_data,
    output logic [TW-1:0]               res_tile
);

    localparam int KW = $clog2(INNER_DIMENSION + FLUSH_CYCLES + 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [TW-1:0]               r_tile;
    logic [TW-1:0]               w_tile_nxt;
    logic [TW-1:0]               r_num_tiles;
    logic [TW-1:0]               w_num_tiles_nxt;
    logic [KW-1:0]               r_k;
    logic [KW-1:0]               w_k_nxt;
    logic                        w_capture;
    logic                        w_res_clr;
    logic                        w_done_nxt;
    logic [AW-1:0]               w_addr_nxt;

    logic                        r_busy;
    logic                        r_done;
    logic                        r_rd_en;
    logic                        r_rd_vld;
    logic [AW-1:0]               r_rd_addr;
    logic                        r_mac_run;
    logic                        r_res_valid;
    logic [WIDTH*CHUNK_SIZE-1:0] r_res_data;
    logic [TW-1:0]               r_res_tile;

    // Address wraps modulo 2^AW by truncation
    assign w_addr_nxt = AW'(int'(w_tile_nxt) * INNER_DIMENSION + int'(w_k_nxt));

    // State, tile index, job length and feed/flush counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tile      <= '0;
            r_num_tiles <= '0;
            r_k         <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tile      <= w_tile_nxt;
            r_num_tiles <= w_num_tiles_nxt;
            r_k         <= w_k_nxt;
        end
    end

    // Next-state logic plus capture/clear/done strobes for the output registers
    always_comb begin
        w_state_nxt     = r_state;
        w_tile_nxt      = r_tile;
        w_num_tiles_nxt = r_num_tiles;
        w_k_nxt         = r_k;
        w_capture       = 1'b0;
        w_res_clr       = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (num_tiles != '0) begin
                        w_state_nxt     = CLEAR;
                        w_tile_nxt      = '0;
                        w_num_tiles_nxt = num_tiles;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            CLEAR: begin
                w_state_nxt = FEED;
                w_k_nxt     = '0;
            end
            FEED: begin
                if (r_k == KW'(INNER_DIMENSION - 1)) begin
                    w_state_nxt = FLUSH;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            FLUSH: begin
                if (mac_acc_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = OUTPUT;
                end else if (r_k == KW'(FLUSH_CYCLES - 1)) begin
                    w_state_nxt = WAIT_ACC;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            WAIT_ACC: begin
                if (mac_acc_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (r_res_valid && res_ready) begin
                    w_res_clr = 1'b1;
                    if (r_tile == r_num_tiles - TW'(1)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = CLEAR;
                        w_tile_nxt  = r_tile + TW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered outputs, all derived from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_addr   <= '0;
            r_mac_run   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tile  <= '0;
        end else begin
            r_busy    <= (w_state_nxt != IDLE) || w_done_nxt;
            r_done    <= w_done_nxt;
            r_rd_en   <= (w_state_nxt == FEED);
            r_rd_addr <= (w_state_nxt == FEED) ? w_addr_nxt : '0;
            r_rd_vld  <= r_rd_en;
            r_mac_run <= !(w_state_nxt inside {IDLE, CLEAR});
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_data  <= mac_out;
                r_res_tile  <= r_tile;
            end else if (w_res_clr) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    mac_skew_feeder #(
        .WIDTH (WIDTH)
    ) u_feeder (
        .clk      (clk),
        .rst      (rst),
        .i_vld    (r_rd_vld),
        .i_a_dat  (a_rd_data),
        .i_b_dat  (b_rd_data),
        .o_west0  (mac_west0),
        .o_west2  (mac_west2),
        .o_north0 (mac_north0),
        .o_north1 (mac_north1)
    );

    assign busy          = r_busy;
    assign done          = r_done;
    assign a_rd_en       = r_rd_en;
    assign b_rd_en       = r_rd_en;
    assign a_rd_addr     = r_rd_addr;
    assign b_rd_addr     = r_rd_addr;
    assign mac_rst_n     = r_mac_run;
    assign mac_reset_acc = r_mac_run;
    assign res_valid     = r_res_valid;
    assign res_data      = r_res_data;
    assign res_tile      = r_res_tile;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural 2x2 systolic MAC model.
// Operand buffers have 1-cycle read latency; MAC done latency is adjustable.
// Consumer readiness is driven per scenario to exercise result backpressure.
module tb_mac_sequencer;

    localparam int WIDTH = 16;
    localparam int CHUNK_SIZE = 4;
    localparam int IDIM = 4;
    localparam int AW = 12;
    localparam int TW = 8;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [TW-1:0]               num_tiles;
    logic                        busy, done, a_rd_en, b_rd_en;
    logic [AW-1:0]               a_rd_addr, b_rd_addr;
    logic [2*WIDTH-1:0]          a_rd_data = '0;
    logic [2*WIDTH-1:0]          b_rd_data = '0;
    logic                        mac_rst_n, mac_reset_acc;
    logic [WIDTH-1:0]            mac_west0, mac_west2, mac_north0, mac_north1;
    logic                        mac_acc_done;
    logic [WIDTH*CHUNK_SIZE-1:0] mac_out;
    logic                        res_valid;
    logic                        res_ready;
    logic [WIDTH*CHUNK_SIZE-1:0] res_data;
    logic [TW-1:0]               res_tile;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_sequencer #(
        .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK_SIZE), .INNER_DIMENSION(IDIM), .AW(AW), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
        .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .mac_rst_n(mac_rst_n), .mac_reset_acc(mac_reset_acc),
        .mac_west0(mac_west0), .mac_west2(mac_west2), .mac_north0(mac_north0), .mac_north1(mac_north1),
        .mac_acc_done(mac_acc_done), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tile(res_tile)
    );

    // Hand-computed tile results {c11,c10,c01,c00} in Q8.8
    logic [63:0] exp_res [0:2];
    initial begin
        exp_res[0] = 64'h1A00_1A00_0A00_0A00;  // 26,26,10,10
        exp_res[1] = 64'h1E00_1E00_0E00_0E00;  // 30,30,14,14
        exp_res[2] = 64'h2200_2200_1200_1200;  // 34,34,18,18
    end

    // Operand buffers: 1-cycle read latency
    logic [2*WIDTH-1:0] a_mem [0:15];
    logic [2*WIDTH-1:0] b_mem [0:15];
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr[3:0]];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr[3:0]];
    end

    // Behavioural 2x2 systolic MAC, Q8.8
    logic [15:0] w0d = '0, n0d = '0, w2d = '0, n1d = '0;
    logic [15:0] acc00 = '0, acc01 = '0, acc10 = '0, acc11 = '0;
    int mcnt = 0;
    int acc_lat = 8;

    function automatic logic [15:0] qmul(input logic [15:0] x, input logic [15:0] y);
        logic signed [31:0] p;
        p = $signed(x) * $signed(y);
        return p[23:8];
    endfunction

    always @(posedge clk) begin
        if (!mac_rst_n) begin
            w0d <= '0; n0d <= '0; w2d <= '0; n1d <= '0;
        end else begin
            w0d <= mac_west0; n0d <= mac_north0; w2d <= mac_west2; n1d <= mac_north1;
        end
        if (!mac_reset_acc) begin
            acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
            mcnt <= 0;
        end else begin
            acc00 <= acc00 + qmul(mac_west0, mac_north0);
            acc01 <= acc01 + qmul(w0d, mac_north1);
            acc10 <= acc10 + qmul(mac_west2, n0d);
            acc11 <= acc11 + qmul(w2d, n1d);
            mcnt  <= mcnt + 1;
        end
    end
    assign mac_acc_done = mac_reset_acc && (mcnt >= acc_lat);
    assign mac_out = {acc11, acc10, acc01, acc00};

    // Observation counters and logs, sampled away from the active edge
    int rd_a_cnt = 0, rd_b_cnt = 0, ab_diff_cnt = 0, done_cnt = 0, res_cnt = 0, rd_while_valid = 0;
    logic [AW-1:0] addr_log [$];
    logic [TW-1:0] tile_log [$];
    logic [63:0]   data_log [$];
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (a_rd_en === 1'b1) begin rd_a_cnt++; addr_log.push_back(a_rd_addr); end
        if (b_rd_en === 1'b1) rd_b_cnt++;
        if (a_rd_en !== b_rd_en || (a_rd_en === 1'b1 && a_rd_addr !== b_rd_addr)) ab_diff_cnt++;
        if (done === 1'b1) done_cnt++;
        if (a_rd_en === 1'b1 && res_valid === 1'b1) rd_while_valid++;
        if (res_valid === 1'b1 && !prev_valid) begin
            res_cnt++; tile_log.push_back(res_tile); data_log.push_back(res_data);
        end
        prev_valid = (res_valid === 1'b1);
    end

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < max) begin @(negedge clk); cyc++; end
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < max) begin @(negedge clk); cyc++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_tiles = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, a_rd_en, b_rd_en, mac_rst_n, mac_reset_acc, res_valid} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, a_rd_en, b_rd_en, mac_rst_n, mac_reset_acc, res_valid});
        end
        n_checks++;
        if ({a_rd_addr, b_rd_addr} !== 24'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h want 0", {a_rd_addr, b_rd_addr});
        end
        n_checks++;
        if ({mac_west0, mac_west2, mac_north0, mac_north1} !== 64'h0) begin
            n_fail++; $display("FAIL reset_operands: got %h want 0", {mac_west0, mac_west2, mac_north0, mac_north1});
        end
        n_checks++;
        if ({res_data, res_tile} !== 72'h0) begin
            n_fail++; $display("FAIL reset_result: got %h want 0", {res_data, res_tile});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_tile();
        int cyc, res0, rd0, done0;
        acc_lat = 8; res_ready = 1'b0;
        res0 = res_cnt; rd0 = rd_a_cnt; done0 = done_cnt;
        start = 1'b1; num_tiles = 8'd1;
        @(negedge clk);
        start = 1'b0; num_tiles = '0;
        n_checks++;
        if ({busy, mac_rst_n, mac_reset_acc, a_rd_en} !== 4'b1000) begin
            n_fail++; $display("FAIL single_clear: got %b want 1000", {busy, mac_rst_n, mac_reset_acc, a_rd_en});
        end
        @(negedge clk);
        n_checks++;
        if ({a_rd_en, b_rd_en, a_rd_addr, mac_rst_n, mac_reset_acc} !== {2'b11, 12'd0, 2'b11}) begin
            n_fail++; $display("FAIL single_feed0: got en=%b addr=%0d mac=%b want en=11 addr=0 mac=11",
                               {a_rd_en, b_rd_en}, a_rd_addr, {mac_rst_n, mac_reset_acc});
        end
        wait_valid(40, cyc);
        n_checks++;
        if (cyc !== 9 || res_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_latency: got %0d cycles valid=%b want 9 cycles valid=1", cyc, res_valid);
        end
        n_checks++;
        if (res_data !== exp_res[0] || res_tile !== 8'd0) begin
            n_fail++; $display("FAIL single_result: got %h tile %0d want %h tile 0", res_data, res_tile, exp_res[0]);
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({res_valid, done, busy} !== 3'b011) begin
            n_fail++; $display("FAIL single_handshake: got valid,done,busy=%b want 011", {res_valid, done, busy});
        end
        res_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL single_idle: got done,busy=%b want 00", {done, busy});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (res_cnt - res0 !== 1 || rd_a_cnt - rd0 !== 4 || done_cnt - done0 !== 1) begin
            n_fail++; $display("FAIL single_counts: got res=%0d rd=%0d done=%0d want 1 4 1",
                               res_cnt - res0, rd_a_cnt - rd0, done_cnt - done0);
        end
    endtask

    task automatic test_multi_tile();
        int cyc, rda0, rdb0, ab0, done0, res0, alog0, tlog0;
        acc_lat = 8; res_ready = 1'b1;
        rda0 = rd_a_cnt; rdb0 = rd_b_cnt; ab0 = ab_diff_cnt; done0 = done_cnt; res0 = res_cnt;
        alog0 = addr_log.size(); tlog0 = tile_log.size();
        start = 1'b1; num_tiles = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, cyc);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL multi_done_timeout: got done=%b after %0d cycles want 1", done, cyc);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (rd_a_cnt - rda0 !== 12 || rd_b_cnt - rdb0 !== 12 || ab_diff_cnt - ab0 !== 0) begin
            n_fail++; $display("FAIL multi_reads: got a=%0d b=%0d mismatch=%0d want 12 12 0",
                               rd_a_cnt - rda0, rd_b_cnt - rdb0, ab_diff_cnt - ab0);
        end
        n_checks++;
        if (done_cnt - done0 !== 1 || res_cnt - res0 !== 3) begin
            n_fail++; $display("FAIL multi_counts: got done=%0d results=%0d want 1 3", done_cnt - done0, res_cnt - res0);
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (addr_log[alog0 + i] !== AW'(i)) begin
                n_fail++; $display("FAIL multi_addr[%0d]: got %0d want %0d", i, addr_log[alog0 + i], i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (tile_log[tlog0 + i] !== TW'(i) || data_log[tlog0 + i] !== exp_res[i]) begin
                n_fail++; $display("FAIL multi_result[%0d]: got tile %0d data %h want tile %0d data %h",
                                   i, tile_log[tlog0 + i], data_log[tlog0 + i], i, exp_res[i]);
            end
        end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc, rdv, rwv0;
        acc_lat = 8; res_ready = 1'b0; rwv0 = rd_while_valid;
        start = 1'b1; num_tiles = 8'd2;
        @(negedge clk);
        start = 1'b0;
        wait_valid(40, cyc);
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_valid_timeout: got valid=%b want 1", res_valid);
        end
        rdv = rd_a_cnt;
        repeat (5) @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b1 || res_tile !== 8'd0 || res_data !== exp_res[0]) begin
            n_fail++; $display("FAIL bp_hold: got valid=%b tile=%0d data=%h want 1 0 %h", res_valid, res_tile, res_data, exp_res[0]);
        end
        n_checks++;
        if (rd_a_cnt - rdv !== 0) begin
            n_fail++; $display("FAIL bp_no_reads: got %0d reads want 0", rd_a_cnt - rdv);
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({res_valid, mac_rst_n, mac_reset_acc, busy} !== 4'b0001) begin
            n_fail++; $display("FAIL bp_clear_after_accept: got %b want 0001", {res_valid, mac_rst_n, mac_reset_acc, busy});
        end
        @(negedge clk);
        n_checks++;
        if (a_rd_en !== 1'b1 || a_rd_addr !== 12'd4) begin
            n_fail++; $display("FAIL bp_tile1_read: got en=%b addr=%0d want 1 4", a_rd_en, a_rd_addr);
        end
        wait_valid(40, cyc);
        n_checks++;
        if (res_tile !== 8'd1 || res_data !== exp_res[1]) begin
            n_fail++; $display("FAIL bp_tile1_result: got tile %0d data %h want 1 %h", res_tile, res_data, exp_res[1]);
        end
        wait_done(20, cyc);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL bp_done_timeout: got done=%b want 1", done);
        end
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_while_valid - rwv0 !== 0) begin
            n_fail++; $display("FAIL bp_read_before_handshake: got %0d want 0", rd_while_valid - rwv0);
        end
    endtask

    task automatic test_zero_tiles();
        int rd0, res0, done0;
        rd0 = rd_a_cnt; res0 = res_cnt; done0 = done_cnt;
        start = 1'b1; num_tiles = 8'd0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({done, busy} !== 2'b11) begin
            n_fail++; $display("FAIL zero_done: got done,busy=%b want 11", {done, busy});
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL zero_pulse_width: got done,busy=%b want 00", {done, busy});
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd_a_cnt - rd0 !== 0 || res_cnt - res0 !== 0 || done_cnt - done0 !== 1) begin
            n_fail++; $display("FAIL zero_counts: got rd=%0d res=%0d done=%0d want 0 0 1",
                               rd_a_cnt - rd0, res_cnt - res0, done_cnt - done0);
        end
    endtask

    task automatic test_reset_mid_feed();
        int cyc, res0, done0;
        acc_lat = 8; res_ready = 1'b1;
        start = 1'b1; num_tiles = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_rd_en !== 1'b1 || a_rd_addr !== 12'd2) begin
            n_fail++; $display("FAIL rst_feed2: got en=%b addr=%0d want 1 2", a_rd_en, a_rd_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, a_rd_en, b_rd_en, mac_rst_n, mac_reset_acc, res_valid} !== 7'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: got %b want 0000000", {busy, done, a_rd_en, b_rd_en, mac_rst_n, mac_reset_acc, res_valid});
        end
        n_checks++;
        if ({a_rd_addr, b_rd_addr, mac_west0, mac_west2, mac_north0, mac_north1} !== 88'h0) begin
            n_fail++; $display("FAIL rst_mid_data: got addr %h operands %h want 0",
                               {a_rd_addr, b_rd_addr}, {mac_west0, mac_west2, mac_north0, mac_north1});
        end
        n_checks++;
        if ({res_data, res_tile} !== 72'h0) begin
            n_fail++; $display("FAIL rst_mid_result: got %h want 0", {res_data, res_tile});
        end
        rst = 1'b0;
        @(negedge clk);
        res0 = res_cnt; done0 = done_cnt;
        start = 1'b1; num_tiles = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60, cyc);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL rst_rerun_timeout: got done=%b want 1", done);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (res_cnt - res0 !== 1 || done_cnt - done0 !== 1 || tile_log[$] !== 8'd0 || data_log[$] !== exp_res[0]) begin
            n_fail++; $display("FAIL rst_rerun_result: got res=%0d done=%0d tile=%0d data=%h want 1 1 0 %h",
                               res_cnt - res0, done_cnt - done0, tile_log[$], data_log[$], exp_res[0]);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        int cyc, rd0, res0, done0;
        acc_lat = 14; res_ready = 1'b1;
        rd0 = rd_a_cnt; res0 = res_cnt; done0 = done_cnt;
        start = 1'b1; num_tiles = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; num_tiles = 8'd5;
        @(negedge clk);
        n_checks++;
        if ({a_rd_en, res_valid, busy} !== 3'b001) begin
            n_fail++; $display("FAIL ign_in_wait: got rd_en,valid,busy=%b want 001", {a_rd_en, res_valid, busy});
        end
        @(negedge clk);
        start = 1'b0; num_tiles = '0;
        wait_done(120, cyc);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL ign_done_timeout: got done=%b want 1", done);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (res_cnt - res0 !== 2 || done_cnt - done0 !== 1 || rd_a_cnt - rd0 !== 8 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ign_counts: got res=%0d done=%0d rd=%0d busy=%b want 2 1 8 0",
                               res_cnt - res0, done_cnt - done0, rd_a_cnt - rd0, busy);
        end
        acc_lat = 8; res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_tiles = '0; res_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 4; k++) begin
                a_mem[t*4 + k] = {16'((5 + k + t) << 8), 16'((1 + k + t) << 8)};
                b_mem[t*4 + k] = {16'h0100, 16'h0100};
            end
        end
        for (int i = 12; i < 16; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_backpressure();
        test_zero_tiles();
        test_reset_mid_feed();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
